// File: rtl/nn_pkg.sv
// Shared constants and state type for the host-side frame parser.
// Command/response byte values are part of the host protocol and must not change.
package nn_pkg;

  localparam logic [7:0] CMD_CLASSIFY = 8'hA5;
  localparam logic [7:0] CMD_TRAIN    = 8'h5A;
  localparam logic [7:0] RESP_ACK     = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    GET_LABEL,
    GET_PIX,
    ISSUE,
    WAIT_ACK,
    SEND_RESP
  } proto_state_t;

endpackage

// File: rtl/uart_protocol_if.sv
// Byte-stream, control_unit handshake and status signals of the frame parser.
// The slave modport is the parser's view; master is the UART/control_unit side.
interface uart_protocol_if #(
  parameter int IMG_SZ = 784 * 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              ack;
  logic              start;
  logic              train;
  logic [7:0]        label;
  logic [IMG_SZ-1:0] image;
  logic              busy;
  logic              err;
  logic              overrun;

  modport slave (
    input  rx_data, rx_valid, tx_ready, ack,
    output tx_data, tx_valid, start, train, label, image, busy, err, overrun
  );

  modport master (
    output rx_data, rx_valid, tx_ready, ack,
    input  tx_data, tx_valid, start, train, label, image, busy, err, overrun
  );
endinterface

// File: rtl/uart_protocol.sv
// Frame parser: command byte, optional label and NUM_PIX pixel bytes into a flat image,
// handshake with control_unit via start/ack, then a one-byte ACK response to the host.
module uart_protocol
  import nn_pkg::*;
#(
  parameter int NUM_PIX     = 784,
  parameter int IMG_SZ      = NUM_PIX * 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic            clk,
  input logic            rst,
  uart_protocol_if.slave bus
);

  localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIX - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  proto_state_t      state_q, state_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              is_train_q, is_train_d;
  logic [7:0]        label_q, label_d;
  logic              overrun_q, overrun_d;
  logic              err_q, err_d;
  logic              start_q, train_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic [IMG_SZ-1:0] image_q;
  logic              pix_we;
  logic [NUM_PIX-1:0] byte_en;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    is_train_d = is_train_q;
    label_d    = label_q;
    overrun_d  = overrun_q;
    err_d      = 1'b0;
    pix_we     = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_TRAIN) begin
            state_d    = GET_LABEL;
            is_train_d = 1'b1;
            pix_cnt_d  = '0;
            overrun_d  = 1'b0;
          end else if (bus.rx_data == CMD_CLASSIFY) begin
            state_d    = GET_PIX;
            is_train_d = 1'b0;
            label_d    = '0;
            pix_cnt_d  = '0;
            overrun_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_LABEL, GET_PIX: begin
        if (bus.rx_valid) begin
          tmo_cnt_d = '0;
          if (state_q == GET_LABEL) begin
            label_d = bus.rx_data;
            state_d = GET_PIX;
          end else begin
            pix_we = 1'b1;
            // Counter stops at the last pixel so it never wraps before the next command.
            if (pix_cnt_q == PIX_LAST) state_d = ISSUE;
            else pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        if (bus.rx_valid) overrun_d = 1'b1;
      end
      WAIT_ACK: begin
        if (bus.ack) state_d = SEND_RESP;
        if (bus.rx_valid) overrun_d = 1'b1;
      end
      SEND_RESP: begin
        if (tx_valid_q && bus.tx_ready) state_d = IDLE;
        if (bus.rx_valid) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NUM_PIX; i++) byte_en[i] = pix_we && (pix_cnt_q == PW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      is_train_q <= 1'b0;
      label_q    <= '0;
      overrun_q  <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      train_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      is_train_q <= is_train_d;
      label_q    <= label_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
      start_q    <= (state_d == ISSUE);
      train_q    <= (state_d == ISSUE) && is_train_d;
      tx_valid_q <= (state_d == SEND_RESP);
      tx_data_q  <= (state_d == SEND_RESP) ? RESP_ACK : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PIX; i++)
        if (byte_en[i]) image_q[8*i +: 8] <= bus.rx_data;
    end
  end

  assign bus.start    = start_q;
  assign bus.train    = train_q;
  assign bus.label    = label_q;
  assign bus.image    = image_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = err_q;
  assign bus.overrun  = overrun_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_protocol.sv
// Scoreboarded bench for uart_protocol: directed frames, error cases and random frames,
// with expected start/err/tx events queued by the driver and consumed by a monitor.
module tb_uart_protocol;

  localparam int NUM_PIX     = 4;
  localparam int IMG_SZ      = NUM_PIX * 8;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_protocol_if #(.IMG_SZ(IMG_SZ)) bus ();

  uart_protocol #(
    .NUM_PIX    (NUM_PIX),
    .IMG_SZ     (IMG_SZ),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_START = 0, EV_ERR = 1, EV_TX = 2} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    logic              train;
    logic [7:0]        label;
    logic [IMG_SZ-1:0] image;
  } ev_t;

  ev_t        exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] mdl_pix[NUM_PIX];
  logic [7:0] mdl_label;
  logic       mdl_ovr;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [IMG_SZ-1:0] mdl_image();
    logic [IMG_SZ-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_PIX; i++) r[8*i +: 8] = mdl_pix[i];
    return r;
  endfunction

  function automatic void push_ev(input ev_kind_t k);
    ev_t e;
    e.kind  = k;
    e.train = 1'b0;
    e.label = mdl_label;
    e.image = mdl_image();
    exp_q.push_back(e);
  endfunction

  // Monitor: every observed output event must match the oldest expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.start || bus.train) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_start: got start=%0b train=%0b expected no event", bus.start, bus.train);
          end else begin
            e = exp_q.pop_front();
            check("start_kind", 64'(int'(EV_START)), 64'(int'(e.kind)));
            check("start_level", bus.start, 1'b1);
            check("start_train", bus.train, e.train);
            check("start_label", bus.label, e.label);
            check("start_image", bus.image, e.image);
          end
        end
        if (bus.err) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_err: got err=1 expected no event");
          end else begin
            e = exp_q.pop_front();
            check("err_kind", 64'(int'(EV_ERR)), 64'(int'(e.kind)));
          end
        end
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_tx: got tx_data=%0h expected no event", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_kind", 64'(int'(EV_TX)), 64'(int'(e.kind)));
            check("tx_data", bus.tx_data, 8'h06);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  // ovr_mode: 0 none, 1 stray byte in WAIT_ACK, 2 stray byte coincident with ack.
  task automatic run_frame(input logic is_train, input logic [7:0] lbl,
                           input logic [IMG_SZ-1:0] pix, input int ovr_mode, input int max_gap);
    ev_t e;
    int  n;
    for (int i = 0; i < NUM_PIX; i++) mdl_pix[i] = pix[8*i +: 8];
    mdl_label = is_train ? lbl : 8'h00;
    mdl_ovr   = 1'b0;
    e.kind  = EV_START;
    e.train = is_train;
    e.label = mdl_label;
    e.image = mdl_image();
    exp_q.push_back(e);

    send_byte(is_train ? 8'h5A : 8'hA5);
    check("ovr_clear_on_cmd", bus.overrun, 1'b0);
    check("busy_in_frame", bus.busy, 1'b1);
    if (is_train) begin
      cycles($urandom_range(max_gap, 0));
      send_byte(lbl);
    end
    for (int i = 0; i < NUM_PIX; i++) begin
      cycles($urandom_range(max_gap, 0));
      send_byte(pix[8*i +: 8]);
    end
    check("start_latency", bus.start, 1'b1);
    check("train_with_start", bus.train, is_train);
    cycles(1);
    check("start_one_cycle", bus.start, 1'b0);
    check("busy_wait_ack", bus.busy, 1'b1);
    cycles($urandom_range(3, 0));

    if (ovr_mode == 1) begin
      send_byte(8'h99);
      mdl_ovr = 1'b1;
    end
    push_ev(EV_TX);
    @(posedge clk); #1;
    bus.ack = 1'b1;
    if (ovr_mode == 2) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h99;
      mdl_ovr      = 1'b1;
    end
    @(posedge clk); #1;
    bus.ack      = 1'b0;
    bus.rx_valid = 1'b0;
    check("image_frozen", bus.image, mdl_image());
    check("label_frozen", bus.label, mdl_label);
    check("overrun_wait", bus.overrun, mdl_ovr);

    n = 0;
    while (!bus.tx_valid && n < 20) begin
      cycles(1);
      n++;
    end
    check("tx_valid_rise", bus.tx_valid, 1'b1);
    cycles($urandom_range(3, 0));
    check("tx_valid_held", bus.tx_valid, 1'b1);
    bus.tx_ready = 1'b1;
    n = 0;
    do begin
      cycles(1);
      n++;
    end while (bus.tx_valid && n < 20);
    bus.tx_ready = 1'b0;
    check("tx_valid_drop", bus.tx_valid, 1'b0);
    check("busy_after_resp", bus.busy, 1'b0);
    check("overrun_sticky", bus.overrun, mdl_ovr);
  endtask

  initial begin
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.ack      = 1'b0;
    for (int i = 0; i < NUM_PIX; i++) mdl_pix[i] = 8'h00;
    mdl_label = 8'h00;
    mdl_ovr   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_start", bus.start, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_image", bus.image, '0);
    check("rst_overrun", bus.overrun, 1'b0);
    rst = 1'b0;
    cycles(2);

    run_frame(1'b0, 8'h00, 32'h04030201, 0, 2);
    check("classify_image", bus.image, 32'h04030201);
    check("classify_label", bus.label, 8'h00);

    run_frame(1'b1, 8'h07, 32'hDDCCBBAA, 0, 2);
    check("train_image", bus.image, 32'hDDCCBBAA);
    check("train_label", bus.label, 8'h07);

    push_ev(EV_ERR);
    send_byte(8'h3C);
    check("badcmd_err", bus.err, 1'b1);
    check("badcmd_busy", bus.busy, 1'b0);
    cycles(1);
    check("badcmd_err_pulse", bus.err, 1'b0);
    cycles(2);

    push_ev(EV_ERR);
    send_byte(8'hA5);
    send_byte(8'h11);
    mdl_pix[0] = 8'h11;
    n = 0;
    while (bus.busy && n < 40) begin
      cycles(1);
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_err", bus.err, 1'b1);
    run_frame(1'b0, 8'h00, 32'h04030201, 0, 1);
    check("after_timeout_image", bus.image, 32'h04030201);

    run_frame(1'b0, 8'h00, 32'h0, 1, 1);
    check("ovr_image_kept", bus.image, 32'h0);
    run_frame(1'b1, 8'h3E, 32'h55667788, 2, 1);
    check("ovr_ack_image", bus.image, 32'h55667788);
    check("ovr_ack_flag", bus.overrun, 1'b1);
    send_byte(8'hA5);
    check("ovr_cleared", bus.overrun, 1'b0);
    for (int i = 0; i < 2; i++) send_byte(8'(i + 1));

    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_image", bus.image, '0);
    check("midrst_label", bus.label, 8'h00);
    check("midrst_start", bus.start, 1'b0);
    check("midrst_tx", bus.tx_valid, 1'b0);
    for (int i = 0; i < NUM_PIX; i++) mdl_pix[i] = 8'h00;
    mdl_label = 8'h00;
    #2;
    rst = 1'b0;
    cycles(1);
    run_frame(1'b0, 8'h00, 32'h44332211, 0, 2);
    check("after_rst_image", bus.image, 32'h44332211);

    for (int f = 0; f < 10; f++) begin
      logic [IMG_SZ-1:0] rp;
      for (int i = 0; i < NUM_PIX; i++) rp[8*i +: 8] = 8'($urandom);
      run_frame(1'($urandom), 8'($urandom), rp, int'($urandom_range(2, 0)), 4);
      check("rand_image", bus.image, rp);
    end

    cycles(3);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
